// File: rtl/tisc_address_map_pkg.sv
// Shared definitions for the TISC address decoder: FSM states, default widths
// and the slave-index width helper.
package tisc_address_map_pkg;

    localparam int WIDTH           = 32;
    localparam int ERR_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // A single-slave build still needs a one-bit index.
    function automatic int idx_width(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage

// File: rtl/tisc_address_match.sv
// Combinational region matcher: reports whether any region hits and the
// index of the lowest-numbered hitting region.
module tisc_address_match
    import tisc_address_map_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = WIDTH,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASES = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] MASKS = '0,
    parameter int IDX_WIDTH  = idx_width(NUM_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0] adr,
    output logic                  hit,
    output logic [IDX_WIDTH-1:0]  idx
);

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((adr & MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (BASES[i*ADDR_WIDTH +: ADDR_WIDTH] & MASKS[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit = 1'b1;
                idx = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/tisc_address_decoder.sv
// Single-master to NUM_SLAVES address decoder with registered slave-side
// request, response timeout, abort handling and a saturating error counter.
module tisc_address_decoder
    import tisc_address_map_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = WIDTH,
    parameter int DATA_WIDTH = WIDTH,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASES = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] MASKS = '0,
    parameter int TIMEOUT    = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             m_cyc_i,
    input  logic                             m_stb_i,
    input  logic                             m_we_i,
    input  logic [ADDR_WIDTH-1:0]            m_adr_i,
    input  logic [DATA_WIDTH-1:0]            m_dat_i,
    input  logic [DATA_WIDTH/8-1:0]          m_sel_i,
    output logic [DATA_WIDTH-1:0]            m_dat_o,
    output logic                             m_ack_o,
    output logic                             m_err_o,
    output logic [NUM_SLAVES-1:0]            s_cyc_o,
    output logic [NUM_SLAVES-1:0]            s_stb_o,
    output logic                             s_we_o,
    output logic [ADDR_WIDTH-1:0]            s_adr_o,
    output logic [DATA_WIDTH-1:0]            s_dat_o,
    output logic [DATA_WIDTH/8-1:0]          s_sel_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]            s_ack_i,
    input  logic [NUM_SLAVES-1:0]            s_err_i,
    output logic [ERR_COUNT_WIDTH-1:0]       err_count_o
);

    localparam int IDX_WIDTH  = idx_width(NUM_SLAVES);
    localparam int TCNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_WIDTH-1:0] TCNT_LAST = TCNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                      state;
    logic [NUM_SLAVES-1:0]       strobe;
    logic [IDX_WIDTH-1:0]        sel_idx;
    logic [TCNT_WIDTH-1:0]       tcnt;
    logic                        hit;
    logic [IDX_WIDTH-1:0]        hit_idx;
    logic                        sel_ack;
    logic                        sel_err;
    logic [DATA_WIDTH-1:0]       sel_dat;
    logic [ERR_COUNT_WIDTH-1:0]  err_count;

    tisc_address_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASES      (BASES),
        .MASKS      (MASKS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_match (
        .adr (m_adr_i),
        .hit (hit),
        .idx (hit_idx)
    );

    // Only the latched slave's response lines are visible to the FSM.
    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (IDX_WIDTH'(i) == sel_idx) begin
                sel_ack = s_ack_i[i];
                sel_err = s_err_i[i];
                sel_dat = s_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            strobe  <= '0;
            sel_idx <= '0;
            tcnt    <= '0;
            s_we_o  <= 1'b0;
            s_adr_o <= '0;
            s_dat_o <= '0;
            s_sel_o <= '0;
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_dat_o <= '0;
        end else begin
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        s_we_o  <= m_we_i;
                        s_adr_o <= m_adr_i;
                        s_dat_o <= m_dat_i;
                        s_sel_o <= m_sel_i;
                        sel_idx <= hit_idx;
                        tcnt    <= '0;
                        if (hit) begin
                            strobe <= NUM_SLAVES'(1) << hit_idx;
                            state  <= ACCESS;
                        end else begin
                            m_err_o <= 1'b1;
                            m_dat_o <= '0;
                            state   <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // An abort wins over any response arriving in the same cycle.
                    if (!m_cyc_i) begin
                        strobe <= '0;
                        state  <= IDLE;
                    end else if (sel_err) begin
                        strobe  <= '0;
                        m_err_o <= 1'b1;
                        m_dat_o <= '0;
                        state   <= RESP;
                    end else if (sel_ack) begin
                        strobe  <= '0;
                        m_ack_o <= 1'b1;
                        m_dat_o <= sel_dat;
                        state   <= RESP;
                    end else if (TIMEOUT != 0 && tcnt == TCNT_LAST) begin
                        strobe  <= '0;
                        m_err_o <= 1'b1;
                        m_dat_o <= '0;
                        state   <= RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP:    state <= HOLD;
                HOLD:    if (!m_stb_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_count <= '0;
        end else if (m_err_o && err_count != {ERR_COUNT_WIDTH{1'b1}}) begin
            err_count <= err_count + 1'b1;
        end
    end

    assign s_cyc_o     = strobe;
    assign s_stb_o     = strobe;
    assign err_count_o = err_count;

endmodule

// File: tb/tb_tisc_address_decoder.sv
// Randomized self-checking bench for tisc_address_decoder against a
// transaction-level model of the decode map and response rules.
module tb_tisc_address_decoder;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            m_cyc_i, m_stb_i, m_we_i;
    logic [AW-1:0]   m_adr_i;
    logic [DW-1:0]   m_dat_i;
    logic [DW/8-1:0] m_sel_i;
    logic [DW-1:0]   m_dat_o;
    logic            m_ack_o, m_err_o;
    logic [NS-1:0]   s_cyc_o, s_stb_o;
    logic            s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic [NS*DW-1:0] s_dat_i;
    logic [NS-1:0]   s_ack_i, s_err_i;
    logic [15:0]     err_count_o;

    int num_checks = 0;
    int num_fails  = 0;
    logic [DW-1:0] exp_dat = '0;
    int exp_err_count = 0;

    tisc_address_decoder #(
        .NUM_SLAVES (NS),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BASES      ({32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
        .MASKS      ({4{32'hFFFF_0000}}),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i (clk_i), .rst_i (rst_i),
        .m_cyc_i (m_cyc_i), .m_stb_i (m_stb_i), .m_we_i (m_we_i),
        .m_adr_i (m_adr_i), .m_dat_i (m_dat_i), .m_sel_i (m_sel_i),
        .m_dat_o (m_dat_o), .m_ack_o (m_ack_o), .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o),
        .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i), .s_ack_i (s_ack_i), .s_err_i (s_err_i),
        .err_count_o (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void note_error();
        if (exp_err_count != 16'hFFFF) exp_err_count++;
    endfunction

    // kind: 0 ack, 1 err, 2 ack+err, 3 silent. intr: other slave answering at cycle 1 (-1 none).
    task automatic apply_stimulus(input logic [31:0] adr, input logic we, input int kind,
                                  input int delay, input int hold_extra, input logic [31:0] rdata,
                                  input int intr, input bit intr_err);
        logic [31:0] wdata = $urandom;
        logic [3:0]  sel   = 4'($urandom);
        int  region  = int'(adr / 32'h10000);
        bit  mapped  = (adr / 32'h10000) < 4;
        int  exp_strobes, exp_cycle;
        bit  exp_err;
        logic [NS-1:0] expect_oh;
        int  strobe_cycles = 0, bad = 0, acks = 0, errs = 0, resp_cycle = -1, drop_at = -1;
        logic [31:0] cap_adr = '0, cap_dat = '0;
        logic [3:0]  cap_sel = '0;
        logic        cap_we  = 1'b0;

        expect_oh = mapped ? NS'(1 << region) : '0;
        for (int i = 0; i < NS; i++) s_dat_i[i*DW +: DW] = $urandom;
        if (mapped) s_dat_i[region*DW +: DW] = rdata;

        if (!mapped) begin
            exp_strobes = 0;  exp_cycle = 1;      exp_err = 1'b1;
        end else if (kind == 3) begin
            exp_strobes = TO; exp_cycle = TO + 1; exp_err = 1'b1;
        end else begin
            exp_strobes = delay; exp_cycle = delay + 1; exp_err = (kind != 0);
        end

        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
        m_adr_i = adr;  m_dat_i = wdata; m_sel_i = sel;

        for (int c = 1; c <= 20; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (s_stb_o != '0) begin
                if (strobe_cycles == 0) begin
                    cap_adr = s_adr_o; cap_dat = s_dat_o; cap_sel = s_sel_o; cap_we = s_we_o;
                end
                strobe_cycles++;
            end
            if ((s_stb_o != '0 && s_stb_o != expect_oh) || s_cyc_o != s_stb_o) bad++;
            if (m_ack_o) acks++;
            if (m_err_o) errs++;
            if ((m_ack_o || m_err_o) && resp_cycle < 0) begin
                resp_cycle = c;
                drop_at    = c + hold_extra;
            end
            if (c == drop_at) begin
                m_cyc_i = 1'b0; m_stb_i = 1'b0;
            end
            s_ack_i = '0; s_err_i = '0;
            if (mapped && kind != 3 && c == delay) begin
                s_ack_i[region] = (kind != 1);
                s_err_i[region] = (kind != 0);
            end
            if (mapped && intr >= 0 && c == 1) begin
                if (intr_err) s_err_i[intr] = 1'b1;
                else          s_ack_i[intr] = 1'b1;
            end
        end
        m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0; s_err_i = '0;
        repeat (2) @(negedge clk_i);

        if (exp_err) begin
            exp_dat = '0;
            note_error();
        end else begin
            exp_dat = rdata;
        end

        check_output("strobe_cycles", 64'(strobe_cycles), 64'(exp_strobes));
        check_output("bad_strobe", 64'(bad), 64'd0);
        check_output("ack_pulses", 64'(acks), exp_err ? 64'd0 : 64'd1);
        check_output("err_pulses", 64'(errs), exp_err ? 64'd1 : 64'd0);
        check_output("resp_cycle", 64'(resp_cycle), 64'(exp_cycle));
        check_output("m_dat_o", 64'(m_dat_o), 64'(exp_dat));
        check_output("err_count_o", 64'(err_count_o), 64'(exp_err_count));
        if (mapped) begin
            check_output("s_adr_o", 64'(cap_adr), 64'(adr));
            check_output("s_dat_o", 64'(cap_dat), 64'(wdata));
            check_output("s_sel_o", 64'(cap_sel), 64'(sel));
            check_output("s_we_o",  64'(cap_we),  64'(we));
        end
    endtask

    initial begin
        int  acks, errs;
        logic [31:0] adr;

        rst_i = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_dat_i = '0; s_ack_i = '0; s_err_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_output("rst_m_dat_o", 64'(m_dat_o), 64'd0);
        check_output("rst_m_resp", 64'({m_ack_o, m_err_o}), 64'd0);
        check_output("rst_s_stb_o", 64'({s_cyc_o, s_stb_o}), 64'd0);
        check_output("rst_err_count", 64'(err_count_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        apply_stimulus(32'h0002_0004, 1'b0, 0, 3, 0, 32'hDEAD_BEEF, -1, 1'b0);
        apply_stimulus(32'h0005_0000, 1'b0, 0, 1, 0, 32'h0, -1, 1'b0);
        apply_stimulus(32'h0001_0010, 1'b0, 3, 1, 0, 32'h1234_5678, -1, 1'b0);
        apply_stimulus(32'h0000_0100, 1'b0, 2, 2, 0, 32'hCAFE_F00D, 3, 1'b0);
        apply_stimulus(32'h0000_0200, 1'b0, 0, 3, 0, 32'hA5A5_0001, 3, 1'b0);
        apply_stimulus(32'h0001_0000, 1'b1, 0, 2, 5, 32'h0BAD_CAFE, -1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int region = $urandom_range(0, 5);
            int intr   = -1;
            adr = (32'(region) << 16) | 32'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) == 0) adr = $urandom;
            if (region < 4 && $urandom_range(0, 1) == 1) intr = (region + 1 + $urandom_range(0, 2)) % NS;
            apply_stimulus(adr, 1'($urandom), $urandom_range(0, 3), $urandom_range(1, 4),
                           $urandom_range(0, 3), $urandom, intr, 1'($urandom));
        end

        // Abort: master drops m_cyc_i in cycle 2 of an access.
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h0001_0000;
        @(posedge clk_i); @(negedge clk_i);
        check_output("abort_stb_c1", 64'(s_stb_o), 64'h2);
        @(posedge clk_i); @(negedge clk_i);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        check_output("abort_stb_c3", 64'({s_cyc_o, s_stb_o}), 64'd0);
        acks = 0; errs = 0;
        for (int c = 0; c < 6; c++) begin
            if (m_ack_o) acks++;
            if (m_err_o) errs++;
            @(negedge clk_i);
        end
        check_output("abort_resp", 64'(acks + errs), 64'd0);
        check_output("abort_m_dat_o", 64'(m_dat_o), 64'(exp_dat));
        check_output("abort_err_count", 64'(err_count_o), 64'(exp_err_count));

        // Reset in cycle 2 of a second access, strobe held so only reset can clear it.
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h0002_0000;
        @(posedge clk_i); @(negedge clk_i);
        check_output("reset_stb_c1", 64'(s_stb_o), 64'h4);
        @(posedge clk_i); @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        exp_dat = '0; exp_err_count = 0;
        check_output("reset_stb_c3", 64'({s_cyc_o, s_stb_o}), 64'd0);
        check_output("reset_m_dat_o", 64'(m_dat_o), 64'd0);
        check_output("reset_err_count", 64'(err_count_o), 64'd0);
        check_output("reset_s_adr_o", 64'(s_adr_o), 64'd0);
        rst_i = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
        acks = 0; errs = 0;
        for (int c = 0; c < 6; c++) begin
            if (m_ack_o) acks++;
            if (m_err_o) errs++;
            if (s_stb_o != '0) errs++;
            @(negedge clk_i);
        end
        check_output("reset_quiet", 64'(acks + errs), 64'd0);

        apply_stimulus(32'h0003_0040, 1'b0, 0, 1, 0, 32'h7777_1111, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
